// File: rtl/sb_tx_packet_serializer_if.sv
// Purpose : request-side handshake bundle for the sideband TX packet serializer.
// Ports   : i_hdr/i_data (CHUNK_W), i_has_data, i_valid driven by the producer;
//           o_ready returned by the serializer (registered, = buffer empty).
interface sb_tx_packet_serializer_if #(
  parameter int CHUNK_W = 64
);
  logic [CHUNK_W-1:0] i_hdr;
  logic [CHUNK_W-1:0] i_data;
  logic               i_has_data;
  logic               i_valid;
  logic               o_ready;

  modport master (
    output i_hdr, i_data, i_has_data, i_valid,
    input  o_ready
  );

  modport slave (
    input  i_hdr, i_data, i_has_data, i_valid,
    output o_ready
  );
endinterface

// File: rtl/sb_tx_packet_serializer.sv
// Purpose : one-entry buffered sideband TX serializer, LSB first, with idle gaps after each chunk.
// Latency : accept edge -> buffer full -> first serial bit two cycles after the accepting cycle.
// Backpr. : o_ready low while the one-entry buffer is full; offers are ignored (not overwritten).
// Ports   : i_pll_clk/i_rst (sync, active-high); io = hdr/data/has_data/valid/ready handshake;
//           o_clk_en (high while a packet is in flight), o_txdatasb (serial data),
//           o_busy (not idle or buffer full), o_pkt_done (one-cycle pulse after the last gap cycle).
module sb_tx_packet_serializer #(
  parameter int CHUNK_W    = 64,
  parameter int GAP_CYCLES = 32
) (
  input  logic                      i_pll_clk,
  input  logic                      i_rst,
  sb_tx_packet_serializer_if.slave  io,
  output logic                      o_clk_en,
  output logic                      o_txdatasb,
  output logic                      o_busy,
  output logic                      o_pkt_done
);

  localparam int BIT_W = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SHIFT_HDR  = 3'd1,
    ST_GAP_HDR    = 3'd2,
    ST_SHIFT_DATA = 3'd3,
    ST_GAP_DATA   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CHUNK_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  // One-entry input buffer.
  logic               buf_full_q, buf_full_d;
  logic [CHUNK_W-1:0] buf_hdr_q, buf_hdr_d;
  logic [CHUNK_W-1:0] buf_data_q, buf_data_d;
  logic               buf_has_data_q, buf_has_data_d;

  // Copy of the in-flight packet's data phase, taken at header load so a new
  // accept into the buffer cannot disturb the packet being transmitted.
  logic [CHUNK_W-1:0] cur_data_q, cur_data_d;
  logic               cur_has_data_q, cur_has_data_d;

  logic               clk_en_q, clk_en_d;
  logic               pkt_done_q, pkt_done_d;

  logic bit_last, gap_last, in_shift, in_gap;
  logic load_hdr, load_data, pkt_end;

  assign bit_last = (bit_cnt_q == BIT_W'(CHUNK_W - 1));
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
  assign in_shift = (state_q == ST_SHIFT_HDR) || (state_q == ST_SHIFT_DATA);
  assign in_gap   = (state_q == ST_GAP_HDR)   || (state_q == ST_GAP_DATA);

  // State register.
  always_ff @(posedge i_pll_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    load_hdr  = 1'b0;
    load_data = 1'b0;
    pkt_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          load_hdr = 1'b1;
          state_d  = ST_SHIFT_HDR;
        end
      end
      ST_SHIFT_HDR: begin
        if (bit_last) state_d = ST_GAP_HDR;
      end
      ST_GAP_HDR: begin
        if (gap_last) begin
          if (cur_has_data_q) begin
            load_data = 1'b1;
            state_d   = ST_SHIFT_DATA;
          end else begin
            pkt_end = 1'b1;
          end
        end
      end
      ST_SHIFT_DATA: begin
        if (bit_last) state_d = ST_GAP_DATA;
      end
      ST_GAP_DATA: begin
        if (gap_last) pkt_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A waiting packet is chained straight into SHIFT_HDR so o_clk_en never drops.
    if (pkt_end) begin
      if (buf_full_q) begin
        load_hdr = 1'b1;
        state_d  = ST_SHIFT_HDR;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Datapath next-state: shifter, counters, buffer.
  always_comb begin
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    buf_full_d     = buf_full_q;
    buf_hdr_d      = buf_hdr_q;
    buf_data_d     = buf_data_q;
    buf_has_data_d = buf_has_data_q;
    cur_data_d     = cur_data_q;
    cur_has_data_d = cur_has_data_q;

    // Counters return to 0 on their terminal value, so every state entry sees 0.
    if (in_shift) begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = bit_last ? '0 : bit_cnt_q + BIT_W'(1);
    end
    if (in_gap) begin
      gap_cnt_d = gap_last ? '0 : gap_cnt_q + GAP_W'(1);
    end

    if (load_data) begin
      shift_d = cur_data_q;
    end

    if (load_hdr) begin
      shift_d        = buf_hdr_q;
      cur_data_d     = buf_data_q;
      cur_has_data_d = buf_has_data_q;
      buf_full_d     = 1'b0;
      bit_cnt_d      = '0;
      gap_cnt_d      = '0;
    end

    // Load needs buf_full_q and accept needs !buf_full_q, so they never collide.
    if (io.i_valid && !buf_full_q) begin
      buf_full_d     = 1'b1;
      buf_hdr_d      = io.i_hdr;
      buf_data_d     = io.i_data;
      buf_has_data_d = io.i_has_data;
    end

    clk_en_d   = (state_d != ST_IDLE);
    pkt_done_d = pkt_end;
  end

  always_ff @(posedge i_pll_clk) begin
    if (i_rst) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      buf_full_q     <= 1'b0;
      buf_hdr_q      <= '0;
      buf_data_q     <= '0;
      buf_has_data_q <= 1'b0;
      cur_data_q     <= '0;
      cur_has_data_q <= 1'b0;
      clk_en_q       <= 1'b0;
      pkt_done_q     <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      buf_full_q     <= buf_full_d;
      buf_hdr_q      <= buf_hdr_d;
      buf_data_q     <= buf_data_d;
      buf_has_data_q <= buf_has_data_d;
      cur_data_q     <= cur_data_d;
      cur_has_data_q <= cur_has_data_d;
      clk_en_q       <= clk_en_d;
      pkt_done_q     <= pkt_done_d;
    end
  end

  // Output logic.
  always_comb begin
    o_clk_en   = clk_en_q;
    o_pkt_done = pkt_done_q;
    o_busy     = (state_q != ST_IDLE) || buf_full_q;
    o_txdatasb = 1'b0;
    if (in_shift) o_txdatasb = shift_q[0];
  end

  assign io.o_ready = ~buf_full_q;

endmodule

// File: tb/tb_sb_tx_packet_serializer.sv
module tb_sb_tx_packet_serializer;
  localparam int CW = 64;
  localparam int GC = 32;

  logic clk = 1'b0;
  logic rst;
  logic clk_en, txd, busy, done;
  int   checks = 0;
  int   errors = 0;

  sb_tx_packet_serializer_if #(.CHUNK_W(CW)) sb_if ();

  sb_tx_packet_serializer #(.CHUNK_W(CW), .GAP_CYCLES(GC)) dut (
    .i_pll_clk (clk),
    .i_rst     (rst),
    .io        (sb_if),
    .o_clk_en  (clk_en),
    .o_txdatasb(txd),
    .o_busy    (busy),
    .o_pkt_done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one packet for a single accepting edge; returns at the sample after that edge.
  task automatic send(input logic [63:0] h, input logic [63:0] d, input logic hd);
    int k;
    k = 0;
    while (sb_if.o_ready !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    checks++;
    if (sb_if.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout ready=%b required=1", sb_if.o_ready);
    end
    sb_if.i_hdr      = h;
    sb_if.i_data     = d;
    sb_if.i_has_data = hd;
    sb_if.i_valid    = 1'b1;
    step();
    sb_if.i_valid    = 1'b0;
  endtask

  // Record n consecutive samples of the serial line plus clk_en/done counts.
  task automatic observe(input int n, output logic [191:0] s, output int en, output int dn);
    s  = '0;
    en = 0;
    dn = 0;
    for (int i = 0; i < n; i++) begin
      s[i] = txd;
      if (clk_en) en++;
      if (done) dn++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sb_if.i_valid = 1'b0;
    sb_if.i_hdr = '0;
    sb_if.i_data = '0;
    sb_if.i_has_data = 1'b0;
    step(); step(); step();
    checks++; if (sb_if.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", sb_if.o_ready); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got=%b want=0", clk_en); end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL reset_txd got=%b want=0", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_header_only();
    logic [191:0] s;
    int en, dn;
    send(64'h0000_0000_0000_00A5, 64'h0, 1'b0);
    checks++; if (sb_if.o_ready !== 1'b0) begin errors++; $display("FAIL hdr_only_ready_after_accept got=%b want=0", sb_if.o_ready); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL hdr_only_clk_en_early got=%b want=0", clk_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hdr_only_busy_buffered got=%b want=1", busy); end
    step();
    observe(96, s, en, dn);
    checks++; if (s[95:0] !== {32'h0, 64'h0000_0000_0000_00A5}) begin errors++; $display("FAIL hdr_only_stream got=%h want=%h", s[95:0], {32'h0, 64'h0000_0000_0000_00A5}); end
    checks++; if (en !== 96) begin errors++; $display("FAIL hdr_only_clk_en_len got=%0d want=96", en); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL hdr_only_early_done got=%0d want=0", dn); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hdr_only_done_97 got=%b want=1", done); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL hdr_only_clk_en_97 got=%b want=0", clk_en); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hdr_only_done_width got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hdr_only_busy_idle got=%b want=0", busy); end
  endtask

  task automatic test_header_data();
    logic [191:0] s;
    int en, dn;
    send({64{1'b1}}, 64'h8000_0000_0000_0001, 1'b1);
    step();
    observe(192, s, en, dn);
    checks++; if (s !== {32'h0, 64'h8000_0000_0000_0001, 32'h0, {64{1'b1}}}) begin errors++; $display("FAIL hdr_data_stream got=%h want=%h", s, {32'h0, 64'h8000_0000_0000_0001, 32'h0, {64{1'b1}}}); end
    checks++; if (en !== 192) begin errors++; $display("FAIL hdr_data_clk_en_len got=%0d want=192", en); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL hdr_data_early_done got=%0d want=0", dn); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hdr_data_done got=%b want=1", done); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL hdr_data_clk_en_end got=%b want=0", clk_en); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hdr_data_done_width got=%b want=0", done); end
  endtask

  task automatic test_back_to_back();
    logic [287:0] s;
    logic [63:0] h1, h2, d2;
    logic r96;
    int en, dn, done_idx, rdy_bad;
    h1 = 64'h1234_5678_9ABC_DEF0;
    h2 = 64'hF00D_CAFE_0BAD_BEEF;
    d2 = 64'h0123_4567_89AB_CDEF;
    s = '0; en = 0; dn = 0; done_idx = -1; rdy_bad = 0; r96 = 1'b0;
    send(h1, 64'h0, 1'b0);
    step();
    for (int i = 0; i < 288; i++) begin
      if (i == 5) begin
        sb_if.i_hdr = h2; sb_if.i_data = d2; sb_if.i_has_data = 1'b1; sb_if.i_valid = 1'b1;
      end
      if (i == 6) sb_if.i_valid = 1'b0;
      if (i >= 6 && i <= 95 && sb_if.o_ready !== 1'b0) rdy_bad++;
      if (i == 96) r96 = sb_if.o_ready;
      s[i] = txd;
      if (clk_en) en++;
      if (done) begin dn++; done_idx = i; end
      step();
    end
    checks++; if (s !== {32'h0, d2, 32'h0, h2, 32'h0, h1}) begin errors++; $display("FAIL b2b_stream got=%h want=%h", s, {32'h0, d2, 32'h0, h2, 32'h0, h1}); end
    checks++; if (en !== 288) begin errors++; $display("FAIL b2b_clk_en_len got=%0d want=288", en); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL b2b_done_count got=%0d want=1", dn); end
    checks++; if (done_idx !== 96) begin errors++; $display("FAIL b2b_done_pos got=%0d want=96", done_idx); end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready_while_full got=%0d want=0", rdy_bad); end
    checks++; if (r96 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_load got=%b want=1", r96); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_final_done got=%b want=1", done); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL b2b_final_clk_en got=%b want=0", clk_en); end
    step();
  endtask

  task automatic test_backpressure();
    logic [191:0] p1, p2;
    logic [63:0] ha, hb;
    int en, dn, rdy_bad;
    ha = 64'h0F0F_0F0F_3C3C_3C3C;
    hb = 64'hC3A5_1234_5678_9ABC;
    p1 = '0; rdy_bad = 0;
    send(ha, 64'h0, 1'b0);
    step();
    for (int i = 0; i < 96; i++) begin
      if (i == 0) begin
        sb_if.i_hdr = hb; sb_if.i_has_data = 1'b0; sb_if.i_valid = 1'b1;
      end
      if (i >= 1 && i <= 50) begin
        if (sb_if.o_ready !== 1'b0) rdy_bad++;
        sb_if.i_hdr = {32'hDEAD_BEEF, 32'(i)};
        sb_if.i_data = {64{1'b1}};
        sb_if.i_has_data = 1'b1;
      end
      if (i == 51) sb_if.i_valid = 1'b0;
      p1[i] = txd;
      step();
    end
    observe(96, p2, en, dn);
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL bp_ready_while_full got=%0d want=0", rdy_bad); end
    checks++; if (p1[95:0] !== {32'h0, ha}) begin errors++; $display("FAIL bp_first_stream got=%h want=%h", p1[95:0], {32'h0, ha}); end
    checks++; if (p2[95:0] !== {32'h0, hb}) begin errors++; $display("FAIL bp_second_stream got=%h want=%h", p2[95:0], {32'h0, hb}); end
    checks++; if (en !== 96) begin errors++; $display("FAIL bp_clk_en_len got=%0d want=96", en); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b want=1", done); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL bp_has_data_kept got=%b want=0", clk_en); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [191:0] s;
    int en, dn, stray;
    send(64'h5555_5555_5555_5555, 64'h0, 1'b1);
    step();
    send(64'hAAAA_0000_AAAA_0000, 64'h1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    checks++; if (sb_if.o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", sb_if.o_ready); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rst_mid_clk_en got=%b want=0", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_mid_txd got=%b want=0", txd); end
    step(); step();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (done !== 1'b0 || clk_en !== 1'b0 || txd !== 1'b0) stray++;
      step();
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_stray_activity got=%0d want=0", stray); end
    send(64'h0000_0000_0000_0081, 64'h0, 1'b0);
    step();
    observe(96, s, en, dn);
    checks++; if (s[95:0] !== {32'h0, 64'h0000_0000_0000_0081}) begin errors++; $display("FAIL rst_mid_next_stream got=%h want=%h", s[95:0], {32'h0, 64'h0000_0000_0000_0081}); end
    checks++; if (en !== 96 || dn !== 0) begin errors++; $display("FAIL rst_mid_next_frame en=%0d dn=%0d want en=96 dn=0", en, dn); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_mid_next_done got=%b want=1", done); end
    step();
  endtask

  task automatic test_random();
    logic [191:0] s, exp;
    logic [63:0] h, d;
    logic hd;
    int n, en, dn;
    for (int it = 0; it < 200; it++) begin
      h  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      hd = 1'($urandom_range(0, 1));
      n  = hd ? 192 : 96;
      exp = hd ? {32'h0, d, 32'h0, h} : {96'h0, 32'h0, h};
      send(h, d, hd);
      step();
      observe(n, s, en, dn);
      checks++; if (s !== exp) begin errors++; $display("FAIL rand_stream it=%0d got=%h want=%h", it, s, exp); end
      checks++; if (en !== n || dn !== 0) begin errors++; $display("FAIL rand_frame it=%0d en=%0d dn=%0d want en=%0d dn=0", it, en, dn, n); end
      checks++; if (done !== 1'b1 || clk_en !== 1'b0 || txd !== 1'b0) begin errors++; $display("FAIL rand_end it=%0d done=%b clk_en=%b txd=%b want 1 0 0", it, done, clk_en, txd); end
      step();
      checks++; if (txd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle it=%0d txd=%b busy=%b want 0 0", it, txd, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_header_only();
    test_header_data();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
